// File: rtl/i2c_pkg.sv
// Shared types and constants for the oversampled I2C register-file target.
package i2c_pkg;

  // Protocol phases of the target; ACK states cover the 9th SCL clock.
  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_IGNORE
  } i2c_state_t;

  // SDA level on the 9th clock: low acknowledges, high refuses.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Width of a register pointer able to address n registers (n >= 2).
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 8; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pad input: 2-flop synchroniser, FILT-sample glitch
// filter, and single-clk rise/fall pulses aligned with the filtered level.
module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic       r_rise;
  logic       r_fall;
  logic [2:0] r_cnt;

  // Bring the asynchronous pad level into the clk domain; idle bus is high.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after FILT consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b1;
      r_cnt   <= 3'd0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= 3'd0;
      end else if (r_cnt == 3'(FILT - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= 3'd0;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C target exposing NREGS 8-bit registers behind an
// auto-incrementing pointer. Runs on clk only; SDA tristate lives at top level.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h27,
  parameter int         NREGS = 4,
  parameter int         FILT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic [8*NREGS-1:0]          regs_out,
  output logic                        wr_stb,
  output logic [ptr_width(NREGS)-1:0] wr_idx,
  output logic                        busy
);

  localparam int PTR_W = ptr_width(NREGS);

  logic w_scl_lvl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda_lvl;
  logic w_sda_rise;
  logic w_sda_fall;
  logic w_start;
  logic w_stop;
  logic [7:0] w_byte;
  logic [7:0] w_rd_byte;

  i2c_state_t       r_state;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_rw;
  logic             r_ack_phase;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [NREGS];
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_wr_stb;
  logic [PTR_W-1:0] r_wr_idx;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (scl_i),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (sda_i),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // Both filters share one latency, so the SCL level is aligned with SDA edges.
  assign w_start   = w_sda_fall & w_scl_lvl;
  assign w_stop    = w_sda_rise & w_scl_lvl;
  assign w_byte    = {r_shift[6:0], w_sda_lvl};
  assign w_rd_byte = r_regs[r_ptr];

  // Bus protocol FSM, register bank and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_idx    <= '0;
      // NOTE: the bank is a small flop array, not a RAM, so it can and must be
      // cleared by reset; fabric logic relies on all-zero registers after rst.
      for (int k = 0; k < NREGS; k++) r_regs[k] <= 8'h00;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_start) begin
        // Also the repeated-START path: always restart address reception.
        r_state     <= S_ADDR;
        r_bit_cnt   <= 4'd0;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_IGNORE: begin
            r_sda_oe <= 1'b0;
          end

          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
                // General call (7'h00) is never acknowledged.
                if (w_byte[7:1] == ADDR && w_byte[7:1] != 7'h00) begin
                  r_rw    <= w_byte[0];
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end

          S_ADDR_ACK: begin
            // First fall opens the ACK bit, second fall closes it.
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= ~I2C_ACK;
                r_ack_phase <= 1'b1;
                r_busy      <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= 4'd0;
                if (r_rw) begin
                  r_shift  <= w_rd_byte;
                  r_sda_oe <= ~w_rd_byte[7];
                  r_ptr    <= r_ptr + 1'b1;
                  r_state  <= S_RDATA;
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= S_PTR;
                end
              end
            end
          end

          S_PTR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_ptr       <= w_byte[PTR_W-1:0];
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
                r_state     <= S_PTR_ACK;
              end
            end
          end

          S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= ~I2C_ACK;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= 4'd0;
                r_state     <= S_WDATA;
              end
            end
          end

          S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_stb      <= 1'b1;
                r_wr_idx      <= r_ptr;
                r_ptr         <= r_ptr + 1'b1;
                r_bit_cnt     <= 4'd0;
                r_ack_phase   <= 1'b0;
                r_state       <= S_WDATA_ACK;
              end
            end
          end

          S_RDATA: begin
            // Shift on the rise so the next bit sits in the MSB for the fall.
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_shift   <= {r_shift[6:0], 1'b0};
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_state     <= S_RACK;
              end else begin
                r_sda_oe <= ~r_shift[7];
              end
            end
          end

          S_RACK: begin
            if (w_scl_rise) begin
              if (w_sda_lvl == I2C_NACK) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_IGNORE;
              end else begin
                r_ack_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_phase) begin
              r_shift     <= w_rd_byte;
              r_sda_oe    <= ~w_rd_byte[7];
              r_ptr       <= r_ptr + 1'b1;
              r_bit_cnt   <= 4'd0;
              r_ack_phase <= 1'b0;
              r_state     <= S_RDATA;
            end
          end

          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Flatten the bank: register k occupies bits [8k+7:8k].
  for (genvar k = 0; k < NREGS; k++) begin : g_regs_out
    assign regs_out[8*k +: 8] = r_regs[k];
  end

  assign sda_oe = r_sda_oe;
  assign busy   = r_busy;
  assign wr_stb = r_wr_stb;
  assign wr_idx = r_wr_idx;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master with a
// scoreboard of expected register writes and expected read bytes.
module tb_i2c_slave_regfile;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [31:0] regs_out;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int oe_cnt   = 0;

  logic [15:0] wr_q [$];  // {index, data} of each write the master issues
  logic [7:0]  rd_q [$];  // bytes the master expects to read back

  // Open-drain bus: the line is low when either side pulls it.
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(.ADDR(7'h27), .NREGS(4), .FILT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .regs_out (regs_out),
    .wr_stb   (wr_stb),
    .wr_idx   (wr_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each write strobe pops the oldest expected write and compares it.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (!rst && wr_stb) begin
      wr_cnt++;
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        check("wr_idx_data", {16'd0, 6'd0, wr_idx, regs_out[8*wr_idx +: 8]}, {16'd0, exp_w});
      end
    end
  end

  always @(posedge clk) if (sda_oe) oe_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, input logic glitch, output logic rb);
    sda_m = b;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q / 2);
    if (glitch) begin
      sda_m = 1'b0;
      wait_clks(1);
      sda_m = b;
      wait_clks(Q / 2 - 1);
    end else begin
      wait_clks(Q / 2);
    end
    rb = sda_line;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    sda_m = 1'b1;
    wait_clks(Q);
  endtask

  // glitch_bit selects the bit (7..0) that gets a 1-clk low pulse; -1 = none.
  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == glitch_bit), rb);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, rb);
      d[i] = rb;
    end
    bus_bit(nack, 1'b0, rb);
  endtask

  initial begin
    logic        ack;
    logic [7:0]  rd;
    logic [7:0]  exp_rd;
    logic [31:0] regs_snap;
    int          wr_snap;
    int          oe_snap;

    // ---------------- reset ----------------
    wait_clks(5);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_wr_idx", {30'd0, wr_idx}, 32'd0);
    check("rst_regs", regs_out, 32'd0);
    rst = 1'b0;
    wait_clks(20);
    check("post_rst_regs", regs_out, 32'd0);

    // ---------------- write: ptr 1, A5, 3C ----------------
    wr_snap = wr_cnt;
    bus_start();
    send_byte(8'h4E, -1, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd0);
    check("wr_busy_after_ack", {31'd0, busy}, 32'd1);
    send_byte(8'h01, -1, ack);
    check("wr_ptr_ack", {31'd0, ack}, 32'd0);
    wr_q.push_back({8'd1, 8'hA5});
    send_byte(8'hA5, -1, ack);
    check("wr_d0_ack", {31'd0, ack}, 32'd0);
    wr_q.push_back({8'd2, 8'h3C});
    send_byte(8'h3C, -1, ack);
    check("wr_d1_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    wait_clks(10);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    check("wr_reg1", {24'd0, regs_out[15:8]}, 32'hA5);
    check("wr_reg2", {24'd0, regs_out[23:16]}, 32'h3C);
    check("wr_strobe_count", 32'(wr_cnt - wr_snap), 32'd2);

    // ---------------- write wrapping: ptr 3, 77, 99 ----------------
    bus_start();
    send_byte(8'h4E, -1, ack);
    send_byte(8'h03, -1, ack);
    wr_q.push_back({8'd3, 8'h77});
    send_byte(8'h77, -1, ack);
    wr_q.push_back({8'd0, 8'h99});
    send_byte(8'h99, -1, ack);
    check("wrap_d1_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    wait_clks(10);
    check("wrap_regs", regs_out, 32'h773CA599);

    // ---------------- read with repeated START from ptr 3 ----------------
    bus_start();
    send_byte(8'h4E, -1, ack);
    send_byte(8'h03, -1, ack);
    check("rd_ptr_ack", {31'd0, ack}, 32'd0);
    bus_start();
    send_byte(8'h4F, -1, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd0);
    rd_q.push_back(8'h77);
    rd_q.push_back(8'h99);
    rd_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) begin
      read_byte((i == 2), rd);
      exp_rd = rd_q.pop_front();
      check($sformatf("rd_byte%0d", i), {24'd0, rd}, {24'd0, exp_rd});
    end
    wait_clks(10);
    check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    bus_stop();
    wait_clks(10);
    check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

    // ---------------- wrong address ----------------
    regs_snap = regs_out;
    wr_snap   = wr_cnt;
    oe_snap   = oe_cnt;
    bus_start();
    send_byte(8'h50, -1, ack);
    check("bad_addr_nack", {31'd0, ack}, 32'd1);
    send_byte(8'h00, -1, ack);
    check("bad_data_nack", {31'd0, ack}, 32'd1);
    bus_stop();
    wait_clks(10);
    check("bad_no_oe", 32'(oe_cnt - oe_snap), 32'd0);
    check("bad_no_wr", 32'(wr_cnt - wr_snap), 32'd0);
    check("bad_regs_kept", regs_out, regs_snap);

    // ---------------- glitch on SDA while SCL high ----------------
    bus_start();
    send_byte(8'h4E, -1, ack);
    check("gl_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h80, 7, ack);
    check("gl_ptr_ack", {31'd0, ack}, 32'd0);
    check("gl_busy_kept", {31'd0, busy}, 32'd1);
    wr_q.push_back({8'd0, 8'h5A});
    send_byte(8'h5A, -1, ack);
    check("gl_data_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    wait_clks(10);
    check("gl_reg0", {24'd0, regs_out[7:0]}, 32'h5A);

    // ---------------- reset mid-read ----------------
    bus_start();
    send_byte(8'h4E, -1, ack);
    send_byte(8'h00, -1, ack);
    bus_start();
    send_byte(8'h4F, -1, ack);
    check("mr_addr_ack", {31'd0, ack}, 32'd0);
    check("mr_oe_driving", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_oe_cleared", {31'd0, sda_oe}, 32'd0);
    check("mr_regs_cleared", regs_out, 32'd0);
    check("mr_busy_cleared", {31'd0, busy}, 32'd0);
    wait_clks(3);
    rst = 1'b0;
    sda_m = 1'b1;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(2 * Q);
    bus_start();
    send_byte(8'h4E, -1, ack);
    check("mr_new_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h02, -1, ack);
    check("mr_new_ptr_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    wait_clks(10);

    // ---------------- pointer truncation: ptr 0x06 -> 2 ----------------
    bus_start();
    send_byte(8'h4E, -1, ack);
    send_byte(8'h06, -1, ack);
    wr_q.push_back({8'd2, 8'h11});
    send_byte(8'h11, -1, ack);
    check("tr_data_ack", {31'd0, ack}, 32'd0);
    bus_stop();
    wait_clks(10);
    check("tr_regs", regs_out, 32'h00110000);

    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
